// File: rtl/alu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pipe_if : operand/result handshake bundle for alu_pipe.          |
// |               Flag signals exist only when ALU_FLAGS_EN is defined.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w;
  logic             illegal;
  logic             busy;
`ifdef ALU_FLAGS_EN
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
`endif

  modport master (
    output in_valid, op, x, y, out_ready,
`ifdef ALU_FLAGS_EN
    input  flag_z, flag_c, flag_v,
`endif
    input  in_ready, out_valid, w, illegal, busy
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
`ifdef ALU_FLAGS_EN
    output flag_z, flag_c, flag_v,
`endif
    output in_ready, out_valid, w, illegal, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pipe : handshaked ALU, registered add/sub/move plus an iterative  |
// |            multiplier. Optional flags enabled by `define ALU_FLAGS_EN.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1,
  parameter int OP_W     = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  localparam logic [OP_W-1:0] c_OP_ADD      = OP_W'(8'h01);
  localparam logic [OP_W-1:0] c_OP_SUB      = OP_W'(8'h02);
  localparam logic [OP_W-1:0] c_OP_MUL      = OP_W'(8'h03);
  localparam logic [OP_W-1:0] c_OP_LDB      = OP_W'(8'h04);
  localparam logic [OP_W-1:0] c_OP_LDW      = OP_W'(8'h05);
  localparam logic [OP_W-1:0] c_OP_STB      = OP_W'(8'h06);
  localparam logic [OP_W-1:0] c_OP_STW      = OP_W'(8'h07);
  localparam logic [OP_W-1:0] c_OP_MOV      = OP_W'(8'h08);
  localparam logic [OP_W-1:0] c_OP_BEQ      = OP_W'(8'h09);
  localparam logic [OP_W-1:0] c_OP_JUMP     = OP_W'(8'h0A);
  localparam logic [OP_W-1:0] c_OP_TLBWRITE = OP_W'(8'h0B);
  localparam logic [OP_W-1:0] c_OP_IRET     = OP_W'(8'h0C);

  localparam int c_ITERS = WIDTH / MUL_BITS;
  localparam int c_CNT_W = $clog2(c_ITERS + 1);
`ifdef ALU_FLAGS_EN
  localparam int c_ACC_W = 2 * WIDTH;  // full product needed for the overflow flags
`else
  localparam int c_ACC_W = WIDTH;
`endif

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             r_state,   w_state_nxt;
  logic               r_out_valid, w_ov_nxt;
  logic [WIDTH-1:0]   r_w,       w_w_nxt;
  logic               r_illegal, w_ill_nxt;
  logic [c_ACC_W-1:0] r_acc,     w_acc_nxt;
  logic [c_ACC_W-1:0] r_mcand,   w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier,  w_mplier_nxt;
  logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;

  logic               w_in_ready, w_accept;
  logic [WIDTH-1:0]   w_sum, w_diff, w_res;
  logic               w_res_ill;
  logic [c_ACC_W-1:0] w_partial, w_acc_sum;

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

`ifdef ALU_FLAGS_EN
  logic [2:0] r_flags, w_flags_nxt;  // {z, c, v}
  logic       w_carry, w_borrow, w_res_c, w_res_v;
  assign {w_carry,  w_sum}  = {1'b0, bus.x} + {1'b0, bus.y};
  assign {w_borrow, w_diff} = {1'b0, bus.x} - {1'b0, bus.y};
`else
  assign w_sum  = bus.x + bus.y;
  assign w_diff = bus.x - bus.y;
`endif

  always_comb begin
    w_res     = '0;
    w_res_ill = 1'b0;
`ifdef ALU_FLAGS_EN
    w_res_c   = 1'b0;
    w_res_v   = 1'b0;
`endif
    case (bus.op)
      c_OP_ADD, c_OP_LDB, c_OP_LDW, c_OP_STB, c_OP_STW: begin
        w_res = w_sum;
`ifdef ALU_FLAGS_EN
        w_res_c = w_carry;
        w_res_v = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (w_sum[WIDTH-1] != bus.x[WIDTH-1]);
`endif
      end
      c_OP_SUB: begin
        w_res = w_diff;
`ifdef ALU_FLAGS_EN
        w_res_c = w_borrow;
        w_res_v = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (w_diff[WIDTH-1] != bus.x[WIDTH-1]);
`endif
      end
      c_OP_MOV: w_res = bus.y;
      c_OP_MUL, c_OP_BEQ, c_OP_JUMP, c_OP_TLBWRITE, c_OP_IRET: w_res = '0;
      default: w_res_ill = 1'b1;
    endcase
  end

  // One MUL_BITS-wide digit of the multiplier per cycle, LSB first.
  assign w_partial = r_mcand * {{(c_ACC_W-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
  assign w_acc_sum = r_acc + w_partial;

  always_comb begin
    w_state_nxt  = r_state;
    w_ov_nxt     = r_out_valid && !bus.out_ready;
    w_w_nxt      = r_w;
    w_ill_nxt    = r_illegal;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
`ifdef ALU_FLAGS_EN
    w_flags_nxt  = r_flags;
`endif
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        if (bus.op == c_OP_MUL) begin
          w_state_nxt  = S_MUL;
          w_acc_nxt    = '0;
          w_mcand_nxt  = c_ACC_W'(bus.x);
          w_mplier_nxt = bus.y;
          w_cnt_nxt    = c_CNT_W'(c_ITERS);
        end else begin
          w_ov_nxt  = 1'b1;
          w_w_nxt   = w_res;
          w_ill_nxt = w_res_ill;
`ifdef ALU_FLAGS_EN
          w_flags_nxt = {(w_res == '0), w_res_c, w_res_v};
`endif
        end
      end
    end else begin
      w_acc_nxt    = w_acc_sum;
      w_mcand_nxt  = r_mcand << MUL_BITS;
      w_mplier_nxt = r_mplier >> MUL_BITS;
      w_cnt_nxt    = r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1)) begin
        w_state_nxt = S_IDLE;
        w_ov_nxt    = 1'b1;
        w_w_nxt     = w_acc_sum[WIDTH-1:0];
        w_ill_nxt   = 1'b0;
`ifdef ALU_FLAGS_EN
        w_flags_nxt = {(w_acc_sum[WIDTH-1:0] == '0),
                       (|w_acc_sum[c_ACC_W-1:WIDTH]),
                       (|w_acc_sum[c_ACC_W-1:WIDTH])};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_w         <= '0;
      r_illegal   <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
`ifdef ALU_FLAGS_EN
      r_flags     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_ov_nxt;
      r_w         <= w_w_nxt;
      r_illegal   <= w_ill_nxt;
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef ALU_FLAGS_EN
      r_flags     <= w_flags_nxt;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.w         = r_w;
  assign bus.illegal   = r_illegal;
  assign bus.busy      = (r_state == S_MUL);
`ifdef ALU_FLAGS_EN
  assign bus.flag_z    = r_flags[2];
  assign bus.flag_c    = r_flags[1];
  assign bus.flag_v    = r_flags[0];
`endif
endmodule
`default_nettype wire
